// File: rtl/ddr_lane_aligner.sv
// Training controller for multi-lane LVDS DDR ADC capture: walks each lane through
// ISERDES bitslip phases and IODELAY taps until its word matches the training pattern.
module ddr_lane_aligner #(
  parameter int                NLANES     = 7,
  parameter int                SER_W      = 4,
  parameter logic [SER_W-1:0]  TRAIN_PAT  = 4'b1100,
  parameter int                DLY_TAPS   = 64,
  parameter int                SETTLE_CYC = 16,
  parameter int                MATCH_CNT  = 64
) (
  input  logic                    sdrClk,
  input  logic                    sdrRst,
  input  logic                    start,
  input  logic [NLANES*SER_W-1:0] sdrData,
  output logic [NLANES-1:0]       bitslip,
  output logic [NLANES-1:0]       dlyCe,
  output logic [NLANES-1:0]       dlyInc,
  output logic                    dlyRst,
  output logic                    busy,
  output logic                    done,
  output logic [NLANES-1:0]       locked,
  output logic [NLANES-1:0]       error
);

  localparam int TAP_W   = (DLY_TAPS > 1) ? $clog2(DLY_TAPS) : 1;
  localparam int SLIP_W  = (SER_W > 1) ? $clog2(SER_W) : 1;
  localparam int MATCH_W = $clog2(MATCH_CNT + 1);
  localparam int LANE_W  = (NLANES > 1) ? $clog2(NLANES) : 1;
  localparam int SET_W   = $clog2(SETTLE_CYC);

  localparam logic [TAP_W-1:0]   TAP_LAST    = TAP_W'(DLY_TAPS - 1);
  localparam logic [SLIP_W-1:0]  SLIP_LAST   = SLIP_W'(SER_W - 1);
  localparam logic [MATCH_W-1:0] MATCH_LAST  = MATCH_W'(MATCH_CNT - 1);
  localparam logic [LANE_W-1:0]  LANE_LAST   = LANE_W'(NLANES - 1);
  localparam logic [SET_W-1:0]   SETTLE_LAST = SET_W'(SETTLE_CYC - 1);
  localparam logic [NLANES-1:0]  LANE_ONE    = NLANES'(1);

  if (SETTLE_CYC < 2) begin : g_settle_check
    $error("ddr_lane_aligner: SETTLE_CYC must be at least 2");
  end

  typedef enum logic [2:0] {
    S_IDLE, S_DLYRST, S_SETTLE, S_CHECK, S_SLIP, S_INC, S_DONE
  } state_t;

  state_t               state;
  logic [LANE_W-1:0]    lane;
  logic [TAP_W-1:0]     tap;
  logic [SLIP_W-1:0]    slip_cnt;
  logic [MATCH_W-1:0]   match_cnt;
  logic [SET_W-1:0]     settle_cnt;

  logic [SER_W-1:0]     words [NLANES];
  logic [NLANES-1:0]    lane_sel;
  logic                 lane_match;
  logic                 lock_hit;
  logic                 give_up;

  for (genvar k = 0; k < NLANES; k++) begin : g_word
    assign words[k] = sdrData[k*SER_W +: SER_W];
  end

  // A lane finishes either by completing its consecutive-match run or by
  // failing on the very last phase of the very last tap.
  assign lane_sel   = LANE_ONE << lane;
  assign lane_match = (words[lane] == TRAIN_PAT);
  assign lock_hit   = lane_match && (match_cnt == MATCH_LAST);
  assign give_up    = !lane_match && (slip_cnt == SLIP_LAST) && (tap == TAP_LAST);

  always_ff @(posedge sdrClk) begin
    if (sdrRst) begin
      state      <= S_IDLE;
      lane       <= '0;
      tap        <= '0;
      slip_cnt   <= '0;
      match_cnt  <= '0;
      settle_cnt <= '0;
      bitslip    <= '0;
      dlyCe      <= '0;
      dlyInc     <= '0;
      dlyRst     <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      locked     <= '0;
      error      <= '0;
    end else begin
      bitslip <= '0;
      dlyCe   <= '0;
      dlyInc  <= '0;
      dlyRst  <= 1'b0;
      done    <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            locked <= '0;
            error  <= '0;
            dlyRst <= 1'b1;
            busy   <= 1'b1;
            state  <= S_DLYRST;
          end
        end
        S_DLYRST: begin
          lane       <= '0;
          tap        <= '0;
          slip_cnt   <= '0;
          settle_cnt <= '0;
          state      <= S_SETTLE;
        end
        S_SETTLE: begin
          match_cnt <= '0;
          if (settle_cnt == SETTLE_LAST) begin
            settle_cnt <= '0;
            state      <= S_CHECK;
          end else begin
            settle_cnt <= settle_cnt + 1'b1;
          end
        end
        S_CHECK: begin
          match_cnt <= lane_match ? match_cnt + 1'b1 : '0;
          if (lock_hit)
            locked <= locked | lane_sel;
          if (give_up)
            error <= error | lane_sel;
          if (lock_hit || give_up) begin
            if (lane == LANE_LAST) begin
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= S_DONE;
            end else begin
              lane     <= lane + 1'b1;
              tap      <= '0;
              slip_cnt <= '0;
              state    <= S_SETTLE;
            end
          end else if (!lane_match) begin
            if (slip_cnt != SLIP_LAST) begin
              bitslip <= lane_sel;
              state   <= S_SLIP;
            end else begin
              dlyCe  <= lane_sel;
              dlyInc <= lane_sel;
              state  <= S_INC;
            end
          end
        end
        S_SLIP: begin
          slip_cnt <= slip_cnt + 1'b1;
          state    <= S_SETTLE;
        end
        S_INC: begin
          tap      <= tap + 1'b1;
          slip_cnt <= '0;
          state    <= S_SETTLE;
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ddr_lane_aligner.sv
// Bench for ddr_lane_aligner: a lane model rotates each lane word on bitslip, and
// expected done timing/lock/error records are queued at launch and popped on done.
module tb_ddr_lane_aligner;

  localparam int NL = 7;
  localparam int SW = 4;
  localparam logic [SW-1:0] PAT = 4'b1100;

  logic            sdrClk = 1'b0;
  logic            sdrRst;
  logic            start;
  logic [NL*SW-1:0] sdrData;
  logic [NL-1:0]   bitslip, dlyCe, dlyInc, locked, error;
  logic            dlyRst, busy, done;

  ddr_lane_aligner #(
    .NLANES(NL), .SER_W(SW), .TRAIN_PAT(PAT), .DLY_TAPS(64),
    .SETTLE_CYC(16), .MATCH_CNT(64)
  ) dut (
    .sdrClk(sdrClk), .sdrRst(sdrRst), .start(start), .sdrData(sdrData),
    .bitslip(bitslip), .dlyCe(dlyCe), .dlyInc(dlyInc), .dlyRst(dlyRst),
    .busy(busy), .done(done), .locked(locked), .error(error)
  );

  always #5 sdrClk = ~sdrClk;

  typedef struct packed {
    int            cyc;
    logic [NL-1:0] lk;
    logic [NL-1:0] er;
    logic          bsy;
  } done_t;

  int compared = 0;
  int mismatched = 0;
  int edge_cnt = 0;
  int start_edge = 0;

  int rot [NL];
  bit dead [NL];
  bit no_rot [NL];
  int glitch_lane = -1;
  int glitch_rel = -1;

  int slip_n [NL];
  int ce_n [NL];
  int inc_n [NL];
  int last_slip [NL];
  int min_gap [NL];
  int dlyrst_n;
  int stray_n;

  done_t exp_q[$];
  done_t obs_q[$];

  always @(posedge sdrClk) edge_cnt++;

  function automatic logic [SW-1:0] rotl(input logic [SW-1:0] w, input int n);
    logic [SW-1:0] r;
    r = w;
    for (int i = 0; i < n % SW; i++) r = {r[SW-2:0], r[SW-1]};
    return r;
  endfunction

  function automatic int total(input int a [NL]);
    int s;
    s = 0;
    for (int i = 0; i < NL; i++) s += a[i];
    return s;
  endfunction

  // Lane model and output monitor; data for the next rising edge is driven here.
  always @(negedge sdrClk) begin
    int rel;
    logic [SW-1:0] w;
    rel = edge_cnt - start_edge;
    for (int k = 0; k < NL; k++) begin
      if (bitslip[k] === 1'b1) begin
        slip_n[k]++;
        if (last_slip[k] >= 0 && rel - last_slip[k] < min_gap[k]) min_gap[k] = rel - last_slip[k];
        last_slip[k] = rel;
        if (!no_rot[k]) rot[k]++;
      end
      if (dlyCe[k] === 1'b1) ce_n[k]++;
      if (dlyInc[k] === 1'b1) inc_n[k]++;
      if (dlyInc[k] === 1'b1 && dlyCe[k] !== 1'b1) stray_n++;
    end
    if ($countones(bitslip | dlyCe) > 1) stray_n++;
    if (dlyRst === 1'b1) dlyrst_n++;
    if (done === 1'b1) obs_q.push_back('{cyc: rel + 1, lk: locked, er: error, bsy: busy});
    for (int k = 0; k < NL; k++) begin
      w = dead[k] ? '0 : rotl(PAT, rot[k]);
      if (k == glitch_lane && rel == glitch_rel) w = ~PAT;
      sdrData[k*SW +: SW] = w;
    end
  end

  task automatic tick();
    @(negedge sdrClk);
    #1;
  endtask

  task automatic clear_model();
    for (int k = 0; k < NL; k++) begin
      rot[k] = 0; dead[k] = 0; no_rot[k] = 0;
      slip_n[k] = 0; ce_n[k] = 0; inc_n[k] = 0;
      last_slip[k] = -1; min_gap[k] = 1000000;
    end
    glitch_lane = -1; glitch_rel = -1;
    dlyrst_n = 0; stray_n = 0;
    obs_q.delete();
    exp_q.delete();
  endtask

  // Returns at the sample point right after the start edge (cycle 1).
  task automatic launch();
    tick();
    start = 1'b1;
    start_edge = edge_cnt + 1;
    tick();
    start = 1'b0;
  endtask

  task automatic await_done(input int budget, output bit got, output done_t ob);
    int n;
    n = 0;
    got = 1'b0;
    ob = '0;
    while (obs_q.size() == 0 && n < budget) begin
      tick();
      n++;
    end
    if (obs_q.size() != 0) begin
      ob = obs_q.pop_front();
      got = 1'b1;
    end
  endtask

  task automatic test_reset();
    sdrRst = 1'b1;
    start = 1'b0;
    repeat (3) tick();
    compared++;
    if ({bitslip, dlyCe, dlyInc} !== '0) begin
      mismatched++; $display("FAIL reset_pulses: got %h want 0", {bitslip, dlyCe, dlyInc});
    end
    compared++;
    if ({dlyRst, busy, done} !== 3'b000) begin
      mismatched++; $display("FAIL reset_ctrl: got %b want 000", {dlyRst, busy, done});
    end
    compared++;
    if ({locked, error} !== '0) begin
      mismatched++; $display("FAIL reset_status: got %h want 0", {locked, error});
    end
    sdrRst = 1'b0;
    tick();
  endtask

  task automatic test_immediate_lock();
    bit got; done_t ob, ex;
    clear_model();
    exp_q.push_back('{cyc: 562, lk: 7'h7F, er: 7'h00, bsy: 1'b0});
    launch();
    compared++;
    if ({busy, dlyRst} !== 2'b11) begin
      mismatched++; $display("FAIL imm_cycle1: got busy,dlyRst=%b want 11", {busy, dlyRst});
    end
    await_done(800, got, ob);
    ex = exp_q.pop_front();
    compared++;
    if (!got) begin mismatched++; $display("FAIL imm_timeout: got no done want done"); end
    compared++;
    if (ob.cyc != ex.cyc) begin mismatched++; $display("FAIL imm_done_cycle: got %0d want %0d", ob.cyc, ex.cyc); end
    compared++;
    if (ob.lk !== ex.lk || ob.er !== ex.er || ob.bsy !== 1'b0) begin
      mismatched++; $display("FAIL imm_status: got lk=%h er=%h busy=%b want lk=%h er=%h busy=0", ob.lk, ob.er, ob.bsy, ex.lk, ex.er);
    end
    compared++;
    if (total(slip_n) != 0 || total(ce_n) != 0) begin
      mismatched++; $display("FAIL imm_pulses: got slips=%0d ce=%0d want 0/0", total(slip_n), total(ce_n));
    end
  endtask

  task automatic test_slip_lane2();
    bit got; done_t ob, ex;
    clear_model();
    rot[2] = 2;
    exp_q.push_back('{cyc: 598, lk: 7'h7F, er: 7'h00, bsy: 1'b0});
    launch();
    await_done(900, got, ob);
    ex = exp_q.pop_front();
    compared++;
    if (!got || ob.cyc != ex.cyc) begin mismatched++; $display("FAIL slip_done_cycle: got %0d want %0d", ob.cyc, ex.cyc); end
    compared++;
    if (ob.lk !== ex.lk || ob.er !== ex.er) begin
      mismatched++; $display("FAIL slip_status: got lk=%h er=%h want lk=%h er=%h", ob.lk, ob.er, ex.lk, ex.er);
    end
    compared++;
    if (slip_n[2] != 2 || total(slip_n) != 2) begin
      mismatched++; $display("FAIL slip_count: got lane2=%0d total=%0d want 2/2", slip_n[2], total(slip_n));
    end
    compared++;
    if (min_gap[2] < 17) begin mismatched++; $display("FAIL slip_gap: got %0d want >=17", min_gap[2]); end
    compared++;
    if (total(ce_n) != 0) begin mismatched++; $display("FAIL slip_ce: got %0d want 0", total(ce_n)); end
  endtask

  task automatic test_intermittent();
    bit got; done_t ob, ex;
    clear_model();
    no_rot[1] = 1;
    exp_q.push_back('{cyc: 643, lk: 7'h7F, er: 7'h00, bsy: 1'b0});
    launch();
    glitch_lane = 1;
    glitch_rel = 160;
    await_done(900, got, ob);
    ex = exp_q.pop_front();
    compared++;
    if (!got || ob.cyc != ex.cyc) begin mismatched++; $display("FAIL inter_done_cycle: got %0d want %0d", ob.cyc, ex.cyc); end
    compared++;
    if (ob.lk !== ex.lk || ob.er !== ex.er) begin
      mismatched++; $display("FAIL inter_status: got lk=%h er=%h want lk=%h er=%h", ob.lk, ob.er, ex.lk, ex.er);
    end
    compared++;
    if (slip_n[1] != 1 || total(slip_n) != 1) begin
      mismatched++; $display("FAIL inter_slips: got lane1=%0d total=%0d want 1/1", slip_n[1], total(slip_n));
    end
  endtask

  task automatic test_dead_lane0();
    bit got; done_t ob, ex;
    clear_model();
    dead[0] = 1;
    exp_q.push_back('{cyc: 5089, lk: 7'h7E, er: 7'h01, bsy: 1'b0});
    launch();
    await_done(6000, got, ob);
    ex = exp_q.pop_front();
    compared++;
    if (!got || ob.cyc != ex.cyc) begin mismatched++; $display("FAIL dead_done_cycle: got %0d want %0d", ob.cyc, ex.cyc); end
    compared++;
    if (ob.lk !== ex.lk || ob.er !== ex.er) begin
      mismatched++; $display("FAIL dead_status: got lk=%h er=%h want lk=%h er=%h", ob.lk, ob.er, ex.lk, ex.er);
    end
    compared++;
    if (slip_n[0] != 192 || total(slip_n) != 192) begin
      mismatched++; $display("FAIL dead_slips: got lane0=%0d total=%0d want 192/192", slip_n[0], total(slip_n));
    end
    compared++;
    if (ce_n[0] != 63 || inc_n[0] != 63 || total(ce_n) != 63) begin
      mismatched++; $display("FAIL dead_inc: got ce=%0d inc=%0d total=%0d want 63", ce_n[0], inc_n[0], total(ce_n));
    end
    compared++;
    if (stray_n != 0) begin mismatched++; $display("FAIL dead_stray: got %0d want 0", stray_n); end
  endtask

  task automatic test_reset_mid();
    bit got; done_t ob, ex;
    clear_model();
    launch();
    repeat (270) tick();
    compared++;
    if (locked !== 7'h07 || busy !== 1'b1) begin
      mismatched++; $display("FAIL mid_before: got lk=%h busy=%b want 07/1", locked, busy);
    end
    sdrRst = 1'b1;
    tick();
    compared++;
    if ({bitslip, dlyCe, dlyInc, dlyRst, busy, done, locked, error} !== '0) begin
      mismatched++; $display("FAIL mid_reset_outputs: got %h want 0", {bitslip, dlyCe, dlyInc, dlyRst, busy, done, locked, error});
    end
    sdrRst = 1'b0;
    repeat (600) tick();
    compared++;
    if (obs_q.size() != 0 || dlyrst_n != 1) begin
      mismatched++; $display("FAIL mid_no_done: got dones=%0d dlyrst=%0d want 0/1", obs_q.size(), dlyrst_n);
    end
    clear_model();
    exp_q.push_back('{cyc: 562, lk: 7'h7F, er: 7'h00, bsy: 1'b0});
    launch();
    compared++;
    if ({busy, dlyRst} !== 2'b11) begin
      mismatched++; $display("FAIL mid_rerun_start: got busy,dlyRst=%b want 11", {busy, dlyRst});
    end
    await_done(800, got, ob);
    ex = exp_q.pop_front();
    compared++;
    if (!got || ob.cyc != ex.cyc || ob.lk !== ex.lk) begin
      mismatched++; $display("FAIL mid_rerun_done: got cyc=%0d lk=%h want cyc=%0d lk=%h", ob.cyc, ob.lk, ex.cyc, ex.lk);
    end
  endtask

  task automatic test_start_held();
    bit got; done_t ob, ex;
    clear_model();
    exp_q.push_back('{cyc: 562, lk: 7'h7F, er: 7'h00, bsy: 1'b0});
    exp_q.push_back('{cyc: 1125, lk: 7'h7F, er: 7'h00, bsy: 1'b0});
    tick();
    start = 1'b1;
    start_edge = edge_cnt + 1;
    await_done(800, got, ob);
    ex = exp_q.pop_front();
    compared++;
    if (!got || ob.cyc != ex.cyc) begin mismatched++; $display("FAIL held_first_done: got %0d want %0d", ob.cyc, ex.cyc); end
    compared++;
    if (dlyrst_n != 1) begin mismatched++; $display("FAIL held_mid_ignored: got dlyrst=%0d want 1", dlyrst_n); end
    tick();
    compared++;
    if ({dlyRst, busy} !== 2'b00) begin
      mismatched++; $display("FAIL held_idle_cycle: got dlyRst,busy=%b want 00", {dlyRst, busy});
    end
    tick();
    compared++;
    if ({dlyRst, busy} !== 2'b11) begin
      mismatched++; $display("FAIL held_restart: got dlyRst,busy=%b want 11", {dlyRst, busy});
    end
    start = 1'b0;
    await_done(800, got, ob);
    ex = exp_q.pop_front();
    compared++;
    if (!got || ob.cyc != ex.cyc || ob.lk !== ex.lk) begin
      mismatched++; $display("FAIL held_second_done: got cyc=%0d lk=%h want cyc=%0d lk=%h", ob.cyc, ob.lk, ex.cyc, ex.lk);
    end
  endtask

  initial begin
    sdrRst = 1'b1;
    start = 1'b0;
    sdrData = '0;
    clear_model();
    test_reset();
    test_immediate_lock();
    test_slip_lane2();
    test_intermittent();
    test_dead_lane0();
    test_reset_mid();
    test_start_held();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no completion want completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/ddr_lane_aligner.md
Name: ddr_lane_aligner

Overview:
- Single-clock training controller for multi-lane LVDS DDR ADC capture.
- Runs in the SDR (divided) clock domain after the per-lane ISERDES.
- Compares each lane's deserialised word against a known training pattern.
- Aligns each lane in turn by pulsing the ISERDES BITSLIP input and stepping a variable data IODELAY. Reports lock or error per lane.

Parameters:
- NLANES, 7, number of DDR data lanes.
- SER_W, 4, bits per lane per sdrClk (ISERDES DATA_WIDTH).
- TRAIN_PAT, 4'b1100, expected lane word. Must be distinct under all SER_W rotations.
- DLY_TAPS, 64, IODELAY tap count.
- SETTLE_CYC, 16, wait cycles after any delay or slip action. Minimum 2, enforced by a generate-time check.
- MATCH_CNT, 64, consecutive matching words required to lock.

Ports:
- sdrClk  in  1  SDR clock. All logic is on this clock.
- sdrRst  in  1  synchronous, active-high reset.
- start  in  1  begin training. Sampled only in IDLE.
- sdrData  in  NLANES*SER_W  lane words. Lane k is sdrData[k*SER_W +: SER_W].
- bitslip  out  NLANES  1-cycle BITSLIP pulse per lane.
- dlyCe  out  NLANES  IODELAY CE pulse per lane.
- dlyInc  out  NLANES  IODELAY INC. Asserted only together with dlyCe.
- dlyRst  out  1  1-cycle reset of all lane IODELAYs to their default tap.
- busy  out  1  training in progress.
- done  out  1  1-cycle pulse when training completes.
- locked  out  NLANES  lane aligned.
- error  out  NLANES  lane exhausted all taps without locking.

Behaviour:
- Reset: every output is 0; state is IDLE; lane, tap, slip and match counters are 0.
- All outputs are registered. sdrRst mid-run aborts immediately to IDLE. No further pulses are emitted.
- IDLE:
  - start=1 clears locked and error.
  - Next state is DLYRST.
  - start while busy=1 is ignored.
- DLYRST (1 cycle):
  - dlyRst=1, busy=1.
  - lane=0, tap=0, slipCnt=0.
  - Next state is SETTLE.
- SETTLE:
  - Count SETTLE_CYC cycles.
  - Clear matchCnt.
  - Next state is CHECK.
- CHECK, compares word[lane] to TRAIN_PAT each cycle:
  - Match: matchCnt++. On reaching MATCH_CNT, set locked[lane] and go to NEXT.
  - Mismatch with slipCnt<SER_W-1: go to SLIP.
  - Mismatch with slipCnt=SER_W-1 and tap<DLY_TAPS-1: go to INC.
  - Mismatch with slipCnt=SER_W-1 and tap=DLY_TAPS-1: set error[lane] and go to NEXT.
  - Match count is consecutive: any mismatch discards partial progress.
- SLIP (1 cycle): bitslip[lane]=1, slipCnt++, then SETTLE.
- INC (1 cycle): dlyCe[lane]=dlyInc[lane]=1, tap++, slipCnt=0, then SETTLE.
  - Because SETTLE separates every action, consecutive bitslip pulses are ≥SETTLE_CYC+1 cycles apart.
- NEXT (0-cycle transition, merged into CHECK exit):
  - If lane=NLANES-1, go to DONE.
  - Otherwise lane++, tap=0, slipCnt=0, then SETTLE for the new lane.
  - The new lane's IODELAY is already at its default from DLYRST.
- DONE (1 cycle): done=1, busy=0, then IDLE.
  - locked and error hold until the next start or sdrRst.
- Only the active lane ever receives bitslip or dlyCe pulses. All other bits stay 0.
- Counter widths:
  - tap: clog2(DLY_TAPS).
  - slipCnt: clog2(SER_W).
  - matchCnt: clog2(MATCH_CNT+1).
  - lane: clog2(NLANES), minimum 1.
- Timing for a lane locking at the first phase, first tap: SETTLE_CYC+MATCH_CNT cycles.
- Whole-run minimum: done is asserted 2+NLANES*(SETTLE_CYC+MATCH_CNT) cycles after the start cycle.

Test Plan:
- Immediate lock, defaults, all lanes driving 1100 constantly; start at cycle 0:
  - busy and dlyRst go high at cycle 1.
  - done pulses at cycle 562 with busy=0.
  - locked=7'h7F, error=0.
  - No bitslip or dlyCe pulses.
- Lane 2 needs 2 slips (model rotates its word one bit per bitslip[2]):
  - Exactly 2 bitslip[2] pulses, ≥17 cycles apart.
  - locked[2]=1.
  - done is delayed by exactly 2*(SETTLE_CYC+1) plus the mismatch cycles versus the immediate-lock run.
- Lane 0 never matches:
  - 3 bitslip[0] pulses per tap, 192 total.
  - 63 dlyCe[0]/dlyInc[0] pulses.
  - Then error[0]=1, locked[0]=0, and training proceeds to lane 1.
- Intermittent match: lane 1 matches 63 cycles, mismatches once, then matches continuously:
  - One bitslip[1] pulse.
  - Lock requires a fresh 64-cycle run.
- sdrRst asserted mid-CHECK on lane 3:
  - Next cycle all outputs are 0 and state is IDLE.
  - No done pulse.
  - A new start reruns from lane 0 with dlyRst.
- start held high through the run and after done:
  - The second run begins only on the cycle after done.
  - Mid-run start pulses have no effect.
